// File: rtl/ac_mac_arbiter.sv
// rtl/ac_mac_arbiter.sv - round-robin session arbiter for a shared Q16.16 sign-magnitude MAC; optional saturation via AC_MAC_SAT_EN
module ac_mac_arbiter #(
   parameter int N = 32,
   parameter int Q = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   output logic         gnt0,
   output logic         gnt1,
   input  logic         op_vld,
   input  logic         op_clr,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         op_rdy,
   output logic [N-1:0] acc,
   output logic         acc_vld,
   output logic         busy,
   output logic         ovf
);

   localparam int M = N - 1;

   typedef enum logic [2:0] {IDLE, GRANT, MUL, ACC, HANDOVER} state_t;

   state_t       state;
   logic         ptr;
   logic [N-1:0] a_r;
   logic [N-1:0] b_r;
   logic         clr_r;
   logic [N-1:0] prod;
   logic [N-1:0] mul_res;
   logic [N-1:0] add_res;
   logic [N-1:0] acc_next;
   logic         req_own;
   logic         sat;

   // request line of whichever requester currently owns the MAC
   assign req_own = gnt0 ? req0 : req1;

`ifdef AC_MAC_SAT_EN
   logic [M:0] sum_mag;
   assign sum_mag = {1'b0, acc[M-1:0]} + {1'b0, prod[M-1:0]};
   assign sat     = (acc[N-1] == prod[N-1]) && sum_mag[M];
`else
   logic [M-1:0] sum_mag;
   assign sum_mag = acc[M-1:0] + prod[M-1:0];
   assign sat     = 1'b0;
`endif

   // qmult: magnitude product truncated back to Q fraction bits, sign is xor
   always_comb begin
      mul_res = {a_r[N-1] ^ b_r[N-1],
                 M'(({{M{1'b0}}, a_r[M-1:0]} * {{M{1'b0}}, b_r[M-1:0]}) >> Q)};
   end

   // qadd: like signs add magnitudes, unlike signs subtract smaller from larger
   always_comb begin
      add_res = '0;
      if (acc[N-1] == prod[N-1]) begin
         add_res = {acc[N-1], sum_mag[M-1:0]};
      end else if (acc[M-1:0] > prod[M-1:0]) begin
         add_res = {acc[N-1], acc[M-1:0] - prod[M-1:0]};
      end else if (acc[M-1:0] < prod[M-1:0]) begin
         add_res = {prod[N-1], prod[M-1:0] - acc[M-1:0]};
      end
   end

   // next accumulator value, clamped to full-scale when saturation is built in
   always_comb begin
      acc_next = add_res;
      if (clr_r) begin
         acc_next = prod;
      end else if (sat) begin
         acc_next = {acc[N-1], {M{1'b1}}};
      end
   end

`ifdef AC_MAC_SAT_EN
   // sticky overflow: cleared on reset or a fresh grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (state == IDLE && (req0 || req1)) begin
         ovf <= 1'b0;
      end else if (state == ACC && !clr_r && sat) begin
         ovf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
`endif

   // session FSM: arbitration, operand handshake, MAC sequencing, handover
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         busy    <= 1'b0;
         op_rdy  <= 1'b0;
         acc     <= '0;
         acc_vld <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         clr_r   <= 1'b0;
         prod    <= '0;
      end else begin
         acc_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  // ptr=0 favours requester 0; after any grant it favours the other one
                  if (req0 && (!req1 || !ptr)) begin
                     gnt0 <= 1'b1;
                     ptr  <= 1'b1;
                  end else begin
                     gnt1 <= 1'b1;
                     ptr  <= 1'b0;
                  end
                  busy   <= 1'b1;
                  op_rdy <= 1'b1;
                  acc    <= '0;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if (op_vld) begin
                  a_r    <= op_a;
                  b_r    <= op_b;
                  clr_r  <= op_clr;
                  op_rdy <= 1'b0;
                  state  <= MUL;
               end else if (!req_own) begin
                  gnt0   <= 1'b0;
                  gnt1   <= 1'b0;
                  busy   <= 1'b0;
                  op_rdy <= 1'b0;
                  state  <= HANDOVER;
               end
            end
            MUL: begin
               prod  <= mul_res;
               state <= ACC;
            end
            ACC: begin
               acc     <= acc_next;
               acc_vld <= 1'b1;
               if (!req_own) begin
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                  busy  <= 1'b0;
                  state <= HANDOVER;
               end else begin
                  op_rdy <= 1'b1;
                  state  <= GRANT;
               end
            end
            HANDOVER: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ac_mac_arbiter.sv
// tb/tb_ac_mac_arbiter.sv - self-checking bench for ac_mac_arbiter against a behavioural MAC/arbiter model
module tb_ac_mac_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic        gnt0, gnt1;
   logic        op_vld, op_clr;
   logic [31:0] op_a, op_b;
   logic        op_rdy;
   logic [31:0] acc;
   logic        acc_vld, busy, ovf;

   int tests_run    = 0;
   int tests_failed = 0;

   ac_mac_arbiter #(.N(32), .Q(16)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .op_vld(op_vld), .op_clr(op_clr), .op_a(op_a), .op_b(op_b), .op_rdy(op_rdy),
      .acc(acc), .acc_vld(acc_vld), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      p = ({33'b0, a[30:0]} * {33'b0, b[30:0]}) >> 16;
      return {a[31] ^ b[31], p[30:0]};
   endfunction

   function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y, output logic of);
      longint unsigned s;
      longint sx, sy, r;
      of = 1'b0;
      if (x[31] == y[31]) begin
         s = {33'b0, x[30:0]} + {33'b0, y[30:0]};
         if (s > 64'h7FFFFFFF) begin
`ifdef AC_MAC_SAT_EN
            of = 1'b1;
            return {x[31], 31'h7FFFFFFF};
`else
            s = s - 64'h80000000;
`endif
         end
         return {x[31], s[30:0]};
      end
      sx = x[31] ? -longint'({33'b0, x[30:0]}) : longint'({33'b0, x[30:0]});
      sy = y[31] ? -longint'({33'b0, y[30:0]}) : longint'({33'b0, y[30:0]});
      r  = sx + sy;
      if (r < 0) begin
         r = -r;
         return {1'b1, r[30:0]};
      end
      return {1'b0, r[30:0]};
   endfunction

   function automatic logic [31:0] nz(input logic [31:0] x);
      return (x == 32'h80000000) ? 32'h0 : x;
   endfunction

   function automatic logic [31:0] rnd_val();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 2))
         0:       return v;
         1:       return {v[31], 11'b0, v[19:0]};
         default: return {v[31], 15'b0, v[15:0]};
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      op_vld = 1'b0; op_clr = 1'b0; op_a = '0; op_b = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic clr,
                        output logic [31:0] res, output int lat);
      int n;
      n = 0;
      while (!op_rdy && n < 20) begin tick(); n++; end
      op_a = a; op_b = b; op_clr = clr; op_vld = 1'b1;
      tick();
      lat = 1;
      op_vld = 1'b0;
      while (!acc_vld && lat < 20) begin tick(); lat++; end
      res = acc;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      op_vld = 1'b0; op_clr = 1'b0; op_a = '0; op_b = '0;
      tick();
      tests_run++;
      if ({gnt0, gnt1, op_rdy, acc_vld, busy, ovf} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b want 000000", {gnt0, gnt1, op_rdy, acc_vld, busy, ovf});
      end
      tests_run++;
      if (acc !== 32'h0) begin tests_failed++; $display("FAIL reset_acc: got %h want 00000000", acc); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [31:0] res; int lat;
      apply_reset();
      req0 = 1'b1;
      tick();
      tests_run++;
      if ({gnt0, gnt1, busy, op_rdy} !== 4'b1011) begin
         tests_failed++; $display("FAIL single_grant: got %b want 1011", {gnt0, gnt1, busy, op_rdy});
      end
      do_op(32'h00010000, 32'h00020000, 1'b1, res, lat);
      tests_run++;
      if (res !== 32'h00020000) begin tests_failed++; $display("FAIL single_acc1: got %h want 00020000", res); end
      tests_run++;
      if (lat !== 3) begin tests_failed++; $display("FAIL single_lat1: got %0d want 3", lat); end
      do_op(32'h00008000, 32'h00020000, 1'b0, res, lat);
      tests_run++;
      if (res !== 32'h00030000) begin tests_failed++; $display("FAIL single_acc2: got %h want 00030000", res); end
      tests_run++;
      if (lat !== 3) begin tests_failed++; $display("FAIL single_lat2: got %0d want 3", lat); end
      tick();
      tests_run++;
      if (acc_vld !== 1'b0) begin tests_failed++; $display("FAIL single_pulse_width: got %b want 0", acc_vld); end
   endtask

   task automatic test_sign();
      logic [31:0] res; int lat;
      apply_reset();
      req0 = 1'b1;
      tick();
      do_op(32'h80010000, 32'h00020000, 1'b1, res, lat);
      tests_run++;
      if (res !== 32'h80020000) begin tests_failed++; $display("FAIL sign_acc1: got %h want 80020000", res); end
      do_op(32'h00008000, 32'h00020000, 1'b0, res, lat);
      tests_run++;
      if (res !== 32'h80010000) begin tests_failed++; $display("FAIL sign_acc2: got %h want 80010000", res); end
   endtask

   task automatic test_contention();
      logic [31:0] res; int lat;
      apply_reset();
      req0 = 1'b1; req1 = 1'b1;
      tick();
      tests_run++;
      if ({gnt0, gnt1} !== 2'b10) begin tests_failed++; $display("FAIL rr_first: got %b want 10", {gnt0, gnt1}); end
      do_op(32'h00010000, 32'h00010000, 1'b1, res, lat);
      tests_run++;
      if ({gnt0, gnt1} !== 2'b10) begin tests_failed++; $display("FAIL rr_hold: got %b want 10", {gnt0, gnt1}); end
      req0 = 1'b0;
      tick();
      tests_run++;
      if ({gnt0, gnt1, busy} !== 3'b000) begin tests_failed++; $display("FAIL rr_handover: got %b want 000", {gnt0, gnt1, busy}); end
      tick();
      tests_run++;
      if ({gnt0, gnt1} !== 2'b00) begin tests_failed++; $display("FAIL rr_idle: got %b want 00", {gnt0, gnt1}); end
      tick();
      tests_run++;
      if ({gnt0, gnt1} !== 2'b01) begin tests_failed++; $display("FAIL rr_second: got %b want 01", {gnt0, gnt1}); end
      tests_run++;
      if (acc !== 32'h0) begin tests_failed++; $display("FAIL rr_acc_clear: got %h want 00000000", acc); end
      req1 = 1'b0;
      tick(); tick(); tick();
      req0 = 1'b1; req1 = 1'b1;
      tick();
      tests_run++;
      if ({gnt0, gnt1} !== 2'b10) begin tests_failed++; $display("FAIL rr_third: got %b want 10", {gnt0, gnt1}); end
   endtask

   task automatic test_illegal();
      int pulses; logic [31:0] held;
      apply_reset();
      req0 = 1'b1;
      tick();
      op_a = 32'h00010000; op_b = 32'h00030000; op_clr = 1'b1; op_vld = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (acc_vld) pulses++; end
      op_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (acc_vld) pulses++; end
      tests_run++;
      if (pulses !== 1) begin tests_failed++; $display("FAIL illegal_hold_pulses: got %0d want 1", pulses); end
      tests_run++;
      if (acc !== 32'h00030000) begin tests_failed++; $display("FAIL illegal_hold_acc: got %h want 00030000", acc); end
      req0 = 1'b0;
      tick(); tick(); tick();
      held = acc;
      op_a = 32'h00020000; op_b = 32'h00020000; op_clr = 1'b1; op_vld = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (acc_vld || gnt0 || gnt1 || op_rdy) pulses++; end
      op_vld = 1'b0;
      tests_run++;
      if (pulses !== 0) begin tests_failed++; $display("FAIL illegal_nogrant_activity: got %0d want 0", pulses); end
      tests_run++;
      if (acc !== 32'h00030000) begin tests_failed++; $display("FAIL illegal_nogrant_acc: got %h want 00030000", acc); end
   endtask

   task automatic test_release_inflight();
      int pulses;
      apply_reset();
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      op_a = 32'h00020000; op_b = 32'h00020000; op_clr = 1'b1; op_vld = 1'b1;
      tick();
      tests_run++;
      if ({gnt0, op_rdy} !== 2'b10) begin tests_failed++; $display("FAIL inflight_mul: got %b want 10", {gnt0, op_rdy}); end
      tick();
      tick();
      tests_run++;
      if ({acc_vld, gnt0, gnt1} !== 3'b100) begin tests_failed++; $display("FAIL inflight_done: got %b want 100", {acc_vld, gnt0, gnt1}); end
      tests_run++;
      if (acc !== 32'h00040000) begin tests_failed++; $display("FAIL inflight_acc: got %h want 00040000", acc); end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (acc_vld || gnt0 || gnt1) pulses++; end
      op_vld = 1'b0;
      tests_run++;
      if (pulses !== 0) begin tests_failed++; $display("FAIL inflight_extra: got %0d want 0", pulses); end
      tests_run++;
      if (acc !== 32'h00040000) begin tests_failed++; $display("FAIL inflight_acc_hold: got %h want 00040000", acc); end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] res; int lat, pulses;
      apply_reset();
      req0 = 1'b1;
      tick();
      do_op(32'h00010000, 32'h00020000, 1'b1, res, lat);
      op_a = 32'h00020000; op_b = 32'h00020000; op_clr = 1'b0; op_vld = 1'b1;
      tick();
      op_vld = 1'b0; req0 = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({gnt0, gnt1, op_rdy, acc_vld, busy, ovf} !== 6'b0) begin
         tests_failed++;
         $display("FAIL midmul_flags: got %b want 000000", {gnt0, gnt1, op_rdy, acc_vld, busy, ovf});
      end
      tests_run++;
      if (acc !== 32'h0) begin tests_failed++; $display("FAIL midmul_acc: got %h want 00000000", acc); end
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (acc_vld || acc != 32'h0) pulses++; end
      tests_run++;
      if (pulses !== 0) begin tests_failed++; $display("FAIL midmul_after: got %0d want 0", pulses); end
   endtask

   task automatic test_sat();
      logic [31:0] res, want; logic want_ovf; int lat;
      apply_reset();
      req0 = 1'b1;
      tick();
      do_op(32'h7FFF0000, 32'h00010000, 1'b1, res, lat);
      tests_run++;
      if (res !== 32'h7FFF0000) begin tests_failed++; $display("FAIL sat_load: got %h want 7fff0000", res); end
      do_op(32'h00010000, 32'h00010000, 1'b0, res, lat);
`ifdef AC_MAC_SAT_EN
      want = 32'h7FFFFFFF; want_ovf = 1'b1;
`else
      want = 32'h00000000; want_ovf = 1'b0;
`endif
      tests_run++;
      if (nz(res) !== want) begin tests_failed++; $display("FAIL sat_edge_acc: got %h want %h", res, want); end
      tests_run++;
      if (ovf !== want_ovf) begin tests_failed++; $display("FAIL sat_edge_ovf: got %b want %b", ovf, want_ovf); end
      do_op(32'h80010000, 32'h00010000, 1'b0, res, lat);
`ifdef AC_MAC_SAT_EN
      want = 32'h7FFEFFFF;
`else
      want = 32'h80010000;
`endif
      tests_run++;
      if (res !== want || ovf !== want_ovf) begin
         tests_failed++; $display("FAIL sat_sticky: got %h/%b want %h/%b", res, ovf, want, want_ovf);
      end
      req0 = 1'b0;
      tick(); tick(); tick();
      req0 = 1'b1;
      tick();
      tests_run++;
      if (ovf !== 1'b0) begin tests_failed++; $display("FAIL sat_clear_on_grant: got %b want 0", ovf); end
   endtask

   task automatic test_random();
      logic [31:0] m_acc, a, b, p, res;
      logic m_ovf, of, clr, m_ptr;
      int lat, who, want_g, nops;
      apply_reset();
      m_ptr = 1'b0;
      for (int s = 0; s < 8; s++) begin
         who = int'($urandom_range(0, 2));
         req0 = (who != 1); req1 = (who != 0);
         want_g = (who == 0) ? 0 : (who == 1) ? 1 : int'(m_ptr);
         m_ptr = (want_g == 0);
         tick();
         tests_run++;
         if ({gnt1, gnt0} !== ((want_g == 1) ? 2'b10 : 2'b01)) begin
            tests_failed++; $display("FAIL rand_grant s=%0d: got gnt1,gnt0=%b want gnt%0d", s, {gnt1, gnt0}, want_g);
         end
         m_acc = 32'h0; m_ovf = 1'b0;
         nops = int'($urandom_range(2, 6));
         for (int k = 0; k < nops; k++) begin
            a = rnd_val(); b = rnd_val(); clr = 1'($urandom_range(0, 1));
            do_op(a, b, clr, res, lat);
            p = m_mul(a, b);
            if (clr) m_acc = p;
            else begin m_acc = m_add(m_acc, p, of); m_ovf = m_ovf | of; end
            tests_run++;
            if (nz(res) !== nz(m_acc) || lat !== 3 || ovf !== m_ovf) begin
               tests_failed++;
               $display("FAIL rand_op s=%0d k=%0d a=%h b=%h clr=%b: got %h lat %0d ovf %b want %h lat 3 ovf %b",
                        s, k, a, b, clr, res, lat, ovf, m_acc, m_ovf);
            end
         end
         req0 = 1'b0; req1 = 1'b0;
         tick(); tick(); tick();
         tests_run++;
         if (nz(acc) !== nz(m_acc) || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rand_release s=%0d: got %h busy %b want %h busy 0", s, acc, busy, m_acc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sign();
      test_contention();
      test_illegal();
      test_release_inflight();
      test_reset_mid_mul();
      test_sat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
